mem_port_arbiter: RTL

//  Shares the single instruction/data memory port between the IF stage (instruction

---
 rtl/mem_port_arbiter_pkg.sv | 16 +
 rtl/mem_arb_select.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM memory port arbiter: FSM state and transaction owner.
// Owner reset value is OWNER_IF.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_REQ  = 2'd1,
      ARB_RESP = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWNER_IF = 1'b0,
      OWNER_DM = 1'b1
   } arb_owner_t;

endpackage

// File: rtl/mem_arb_select.sv
// Winner select for the shared memory port: data first, but a waiting fetch is forced through
// after MAX_DATA_STREAK consecutive data wins. Combinational winner; streak updates on accept.
module mem_arb_select
   import mem_port_arbiter_pkg::*;
#(
   parameter int MAX_DATA_STREAK = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       if_req,
   input  logic       dm_req,
   input  logic       accept,
   output arb_owner_t winner
);

   localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

   logic [STREAK_W-1:0] streak_q;

   always_comb begin
      winner = OWNER_IF;
      if (dm_req && !(if_req && streak_q == STREAK_MAX)) begin
         winner = OWNER_DM;
      end
   end

   // Only data wins that leave a fetch waiting count towards starvation.
   always_ff @(posedge clock) begin
      if (reset) begin
         streak_q <= '0;
      end else if (accept) begin
         if (winner == OWNER_DM && if_req) begin
            if (streak_q != STREAK_MAX) begin
               streak_q <= streak_q + 1'b1;
            end
         end else begin
            streak_q <= '0;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory req/gnt/rvalid port between fetch and load/store, one transaction at a time.
// Request sampled in N -> gnt at N+1 -> rvalid at N+2; requesters hold req until their gnt.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W          = 32,
   parameter int DATA_W          = 32,
   parameter int MAX_DATA_STREAK = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                if_req_ip,
   input  logic [ADDR_W-1:0]   if_addr_ip,
   input  logic                if_flush_ip,
   output logic                if_gnt_op,
   output logic                if_rvalid_op,
   output logic [DATA_W-1:0]   if_rdata_op,
   output logic                if_stall_op,
   input  logic                dm_req_ip,
   input  logic                dm_we_ip,
   input  logic [DATA_W/8-1:0] dm_be_ip,
   input  logic [ADDR_W-1:0]   dm_addr_ip,
   input  logic [DATA_W-1:0]   dm_wdata_ip,
   output logic                dm_gnt_op,
   output logic                dm_rvalid_op,
   output logic [DATA_W-1:0]   dm_rdata_op,
   output logic                mem_req_op,
   output logic                mem_we_op,
   output logic [DATA_W/8-1:0] mem_be_op,
   output logic [ADDR_W-1:0]   mem_addr_op,
   output logic [DATA_W-1:0]   mem_wdata_op,
   input  logic                mem_gnt_ip,
   input  logic                mem_rvalid_ip,
   input  logic [DATA_W-1:0]   mem_rdata_ip
);

   localparam int BE_W = DATA_W / 8;

   arb_state_t        state_q, state_d;
   arb_owner_t        owner_q;
   arb_owner_t        winner;
   logic              drop_q;
   logic              accept;
   logic              req_we_q;
   logic [BE_W-1:0]   req_be_q;
   logic [ADDR_W-1:0] req_addr_q;
   logic [DATA_W-1:0] req_wdata_q;

   assign accept = (state_q == ARB_IDLE) && (if_req_ip || dm_req_ip);

   mem_arb_select #(
      .MAX_DATA_STREAK(MAX_DATA_STREAK)
   ) u_select (
      .clock  (clock),
      .reset  (reset),
      .if_req (if_req_ip),
      .dm_req (dm_req_ip),
      .accept (accept),
      .winner (winner)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ARB_IDLE;
         owner_q     <= OWNER_IF;
         drop_q      <= 1'b0;
         req_we_q    <= 1'b0;
         req_be_q    <= '0;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            owner_q <= winner;
            if (winner == OWNER_DM) begin
               req_we_q    <= dm_we_ip;
               req_be_q    <= dm_be_ip;
               req_addr_q  <= dm_addr_ip;
               req_wdata_q <= dm_wdata_ip;
            end else begin
               req_we_q    <= 1'b0;
               req_be_q    <= '1;
               req_addr_q  <= if_addr_ip;
               req_wdata_q <= '0;
            end
         end
         // A flushed fetch still finishes on the bus; only its response is hidden.
         if (state_q == ARB_IDLE) begin
            drop_q <= 1'b0;
         end else if (owner_q == OWNER_IF && if_flush_ip) begin
            drop_q <= 1'b1;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      if_gnt_op    = 1'b0;
      if_rvalid_op = 1'b0;
      if_rdata_op  = '0;
      dm_gnt_op    = 1'b0;
      dm_rvalid_op = 1'b0;
      dm_rdata_op  = '0;
      mem_req_op   = 1'b0;
      mem_we_op    = 1'b0;
      mem_be_op    = '0;
      mem_addr_op  = '0;
      mem_wdata_op = '0;
      if_stall_op  = if_req_ip && !(owner_q == OWNER_IF && state_q != ARB_IDLE);
      case (state_q)
         ARB_IDLE: begin
            if (accept) begin
               state_d = ARB_REQ;
            end
         end
         ARB_REQ: begin
            mem_req_op   = 1'b1;
            mem_we_op    = req_we_q;
            mem_be_op    = req_be_q;
            mem_addr_op  = req_addr_q;
            mem_wdata_op = req_wdata_q;
            if (mem_gnt_ip) begin
               state_d = ARB_RESP;
               if (owner_q == OWNER_DM) begin
                  dm_gnt_op = 1'b1;
               end else begin
                  if_gnt_op = 1'b1;
               end
            end
         end
         ARB_RESP: begin
            if (mem_rvalid_ip) begin
               state_d = ARB_IDLE;
               if (owner_q == OWNER_DM) begin
                  dm_rvalid_op = 1'b1;
                  dm_rdata_op  = mem_rdata_ip;
               end else if (!drop_q && !if_flush_ip) begin
                  if_rvalid_op = 1'b1;
                  if_rdata_op  = mem_rdata_ip;
               end
            end
         end
         default: state_d = ARB_IDLE;
      endcase
      // Outputs stay quiet while reset is held, whatever state is still registered.
      if (reset) begin
         if_gnt_op    = 1'b0;
         if_rvalid_op = 1'b0;
         if_rdata_op  = '0;
         if_stall_op  = 1'b0;
         dm_gnt_op    = 1'b0;
         dm_rvalid_op = 1'b0;
         dm_rdata_op  = '0;
         mem_req_op   = 1'b0;
         mem_we_op    = 1'b0;
         mem_be_op    = '0;
         mem_addr_op  = '0;
         mem_wdata_op = '0;
      end
   end

   a_if_req_held: assert property (@(posedge clock) disable iff (reset)
      (state_q == ARB_REQ && owner_q == OWNER_IF && !mem_gnt_ip) |-> if_req_ip);

   a_dm_req_held: assert property (@(posedge clock) disable iff (reset)
      (state_q == ARB_REQ && owner_q == OWNER_DM && !mem_gnt_ip) |-> dm_req_ip);

endmodule
